// File: rtl/rs_pcie_cq_cc_completer.sv
// PCIe completer endpoint: single-DW MemRd/MemWr TLPs from the 512-bit CQ stream become
// register-bus accesses, and reads are answered with a one-beat CC completion.
module rs_pcie_cq_cc_completer #(
  parameter int          ADDR_W         = 20,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic              user_clk,
  input  logic              user_reset,
  input  logic              s_axis_cq_tvalid,
  input  logic [511:0]      s_axis_cq_tdata,
  input  logic [15:0]       s_axis_cq_tkeep,
  input  logic [182:0]      s_axis_cq_tuser,
  input  logic              s_axis_cq_tlast,
  output logic              s_axis_cq_tready,
  output logic              m_axis_cc_tvalid,
  output logic [511:0]      m_axis_cc_tdata,
  output logic [15:0]       m_axis_cc_tkeep,
  output logic [80:0]       m_axis_cc_tuser,
  output logic              m_axis_cc_tlast,
  input  logic              m_axis_cc_tready,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  output logic [3:0]        reg_be,
  input  logic [31:0]       reg_rdata,
  input  logic              reg_rd_valid
);
  localparam int         CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] REQ_MEM_RD = 4'b0000;
  localparam logic [3:0] REQ_MEM_WR = 4'b0001;
  localparam logic [2:0] CPL_SC     = 3'b000;
  localparam logic [2:0] CPL_UR     = 3'b001;

  typedef enum logic [2:0] {IDLE, DRAIN, WR, RD_REQ, RD_WAIT, CPL} state_e;

  state_e            state_q, state_d, pend_q, pend_d, sop_action;
  logic              cq_tready_q;
  logic [ADDR_W-3:0] addr_q;
  logic [3:0]        be_q;
  logic [15:0]       req_id_q;
  logic [7:0]        tag_q;
  logic [2:0]        tc_q, attr_q, status_q;
  logic [31:0]       wdata_q, data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cq_fire, timeout;
  logic [3:0]        sop_type;
  logic [10:0]       sop_dw_cnt;
  logic [1:0]        lo2;
  logic [12:0]       byte_cnt;
  logic [127:0]      cc_desc;
  logic              unused_ok;

  assign cq_fire    = s_axis_cq_tvalid && cq_tready_q;
  assign sop_type   = s_axis_cq_tdata[78:75];
  assign sop_dw_cnt = s_axis_cq_tdata[74:64];
  assign timeout    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign unused_ok  = ^{s_axis_cq_tkeep, s_axis_cq_tuser, s_axis_cq_tdata};

  // Action implied by the SOP beat; IDLE means the TLP is dropped without a response.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    sop_action = IDLE;
    if (!s_axis_cq_tuser[96]) begin
      if (sop_type == REQ_MEM_WR && sop_dw_cnt == 11'd1) sop_action = WR;
      else if (sop_type == REQ_MEM_RD) sop_action = (sop_dw_cnt == 11'd1) ? RD_REQ : CPL;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: if (cq_fire) begin
        if (s_axis_cq_tlast) begin
          state_d = sop_action;
        end else begin
          state_d = DRAIN;
          pend_d  = sop_action;
        end
      end
      DRAIN:   if (cq_fire && s_axis_cq_tlast) state_d = pend_q;
      WR:      state_d = IDLE;
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: if (reg_rd_valid || timeout) state_d = CPL;
      CPL:     if (m_axis_cc_tready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
      state_q     <= IDLE;
      pend_q      <= IDLE;
      cq_tready_q <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      req_id_q    <= '0;
      tag_q       <= '0;
      tc_q        <= '0;
      attr_q      <= '0;
      status_q    <= CPL_SC;
      wdata_q     <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      cq_tready_q <= (state_d == IDLE) || (state_d == DRAIN);
      if (state_q == IDLE && cq_fire) begin
        addr_q   <= s_axis_cq_tdata[ADDR_W-1:2];
        be_q     <= s_axis_cq_tuser[3:0];
        req_id_q <= s_axis_cq_tdata[95:80];
        tag_q    <= s_axis_cq_tdata[103:96];
        tc_q     <= s_axis_cq_tdata[123:121];
        attr_q   <= s_axis_cq_tdata[126:124];
        wdata_q  <= s_axis_cq_tdata[159:128];
        status_q <= (sop_dw_cnt == 11'd1) ? CPL_SC : CPL_UR;
        data_q   <= '0;
      end
      if (state_q == RD_REQ) cnt_q <= '0;
      else if (state_q == RD_WAIT) cnt_q <= cnt_q + CNT_W'(1);
      // Real read data takes priority over a timeout landing in the same cycle.
      if (state_q == RD_WAIT) begin
        if (reg_rd_valid) begin
          data_q   <= reg_rdata;
          status_q <= CPL_SC;
        end else if (timeout) begin
          data_q   <= TIMEOUT_DATA;
          status_q <= CPL_SC;
        end
      end
    end
  end

  always_comb begin
    lo2 = 2'd0;
    casez (be_q)
      4'b???1: lo2 = 2'd0;
      4'b??10: lo2 = 2'd1;
      4'b?100: lo2 = 2'd2;
      4'b1000: lo2 = 2'd3;
      default: lo2 = 2'd0;
    endcase
    byte_cnt = 13'd1;
    casez (be_q)
      4'b1??1:                   byte_cnt = 13'd4;
      4'b01?1, 4'b1?10:          byte_cnt = 13'd3;
      4'b0011, 4'b0110, 4'b1100: byte_cnt = 13'd2;
      default:                   byte_cnt = 13'd1;
    endcase
    if (status_q == CPL_UR) byte_cnt = 13'd4;
  end

  always_comb begin
    cc_desc          = '0;
    cc_desc[6:0]     = {addr_q[4:0], lo2};
    cc_desc[28:16]   = byte_cnt;
    cc_desc[42:32]   = (status_q == CPL_UR) ? 11'd0 : 11'd1;
    cc_desc[45:43]   = status_q;
    cc_desc[63:48]   = req_id_q;
    cc_desc[71:64]   = tag_q;
    cc_desc[91:89]   = tc_q;
    cc_desc[94:92]   = attr_q;
    cc_desc[127:96]  = data_q;
  end

  assign s_axis_cq_tready = cq_tready_q;
  assign m_axis_cc_tvalid = (state_q == CPL);
  assign m_axis_cc_tlast  = (state_q == CPL);
  assign m_axis_cc_tuser  = '0;
  assign m_axis_cc_tkeep  = (state_q != CPL) ? 16'h0000 :
                            (status_q == CPL_UR) ? 16'h0007 : 16'h000F;
  assign m_axis_cc_tdata  = (state_q == CPL) ? {384'd0, cc_desc} : 512'd0;
  assign reg_wr_en        = (state_q == WR);
  assign reg_rd_en        = (state_q == RD_REQ);
  assign reg_addr         = {addr_q, 2'b00};
  assign reg_wdata        = wdata_q;
  assign reg_be           = be_q;
endmodule

// File: tb/tb_rs_pcie_cq_cc_completer.sv
// Randomized bench for the CQ/CC completer: directed corner cases, then random TLP mixes
// compared against a transaction-level model of the expected register and CC behaviour.
module tb_rs_pcie_cq_cc_completer;
  localparam int          ADDR_W   = 20;
  localparam int          TMO      = 16;
  localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

  logic              user_clk = 1'b0;
  logic              user_reset;
  logic              s_axis_cq_tvalid, s_axis_cq_tlast, s_axis_cq_tready;
  logic [511:0]      s_axis_cq_tdata;
  logic [15:0]       s_axis_cq_tkeep;
  logic [182:0]      s_axis_cq_tuser;
  logic              m_axis_cc_tvalid, m_axis_cc_tlast, m_axis_cc_tready;
  logic [511:0]      m_axis_cc_tdata;
  logic [15:0]       m_axis_cc_tkeep;
  logic [80:0]       m_axis_cc_tuser;
  logic              reg_wr_en, reg_rd_en, reg_rd_valid;
  logic [ADDR_W-1:0] reg_addr;
  logic [31:0]       reg_wdata, reg_rdata;
  logic [3:0]        reg_be;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [61:0] dw_addr;
    logic [10:0] dw_cnt;
    logic [3:0]  req_type;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [2:0]  attr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        disc;
  } req_t;

  typedef enum {ACT_NONE, ACT_WR, ACT_RD, ACT_UR} act_e;

  rs_pcie_cq_cc_completer #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO), .TIMEOUT_DATA(TMO_DATA)) dut (
    .user_clk(user_clk), .user_reset(user_reset),
    .s_axis_cq_tvalid(s_axis_cq_tvalid), .s_axis_cq_tdata(s_axis_cq_tdata),
    .s_axis_cq_tkeep(s_axis_cq_tkeep), .s_axis_cq_tuser(s_axis_cq_tuser),
    .s_axis_cq_tlast(s_axis_cq_tlast), .s_axis_cq_tready(s_axis_cq_tready),
    .m_axis_cc_tvalid(m_axis_cc_tvalid), .m_axis_cc_tdata(m_axis_cc_tdata),
    .m_axis_cc_tkeep(m_axis_cc_tkeep), .m_axis_cc_tuser(m_axis_cc_tuser),
    .m_axis_cc_tlast(m_axis_cc_tlast), .m_axis_cc_tready(m_axis_cc_tready),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_be(reg_be), .reg_rdata(reg_rdata),
    .reg_rd_valid(reg_rd_valid)
  );

  always #5 user_clk = ~user_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic act_e classify(input req_t r);
    if (r.disc) return ACT_NONE;
    if (r.req_type == 4'b0001 && r.dw_cnt == 11'd1) return ACT_WR;
    if (r.req_type == 4'b0000) return (r.dw_cnt == 11'd1) ? ACT_RD : ACT_UR;
    return ACT_NONE;
  endfunction

  function automatic int first_one(input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) return i;
    return 0;
  endfunction

  // Bytes covered from lowest to highest enabled lane; an empty mask still counts one byte.
  function automatic int byte_span(input logic [3:0] be);
    int hi;
    if (be == 4'b0000) return 1;
    hi = 0;
    for (int i = 0; i < 4; i++) if (be[i]) hi = i;
    return hi - first_one(be) + 1;
  endfunction

  function automatic logic [511:0] exp_cc(input req_t r, input bit ur, input logic [31:0] data);
    logic [511:0] d;
    int lower;
    d = '0;
    lower = (int'(r.dw_addr[4:0]) * 4 + first_one(r.be)) % 128;
    d[6:0]    = 7'(lower);
    d[28:16]  = ur ? 13'd4 : 13'(byte_span(r.be));
    d[42:32]  = ur ? 11'd0 : 11'd1;
    d[45:43]  = ur ? 3'b001 : 3'b000;
    d[63:48]  = r.req_id;
    d[71:64]  = r.tag;
    d[91:89]  = r.tc;
    d[94:92]  = r.attr;
    d[127:96] = ur ? 32'h0 : data;
    return d;
  endfunction

  function automatic logic [511:0] cq_sop(input req_t r);
    logic [511:0] d;
    d = '0;
    d[63:2]    = r.dw_addr;
    d[74:64]   = r.dw_cnt;
    d[78:75]   = r.req_type;
    d[95:80]   = r.req_id;
    d[103:96]  = r.tag;
    d[123:121] = r.tc;
    d[126:124] = r.attr;
    d[159:128] = r.wdata;
    return d;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    r.dw_addr  = t[61:0];
    r.dw_cnt   = 11'd1;
    r.req_type = 4'b0000;
    r.req_id   = 16'($urandom());
    r.tag      = 8'($urandom());
    r.tc       = 3'($urandom());
    r.attr     = 3'($urandom());
    r.wdata    = $urandom();
    r.be       = 4'($urandom());
    r.disc     = 1'b0;
    return r;
  endfunction

  // ---------------- stimulus / checking tasks ----------------
  task automatic send_beat(input logic [511:0] data, input logic [3:0] be, input logic disc,
                           input logic last);
    int n;
    n = 0;
    s_axis_cq_tvalid     = 1'b1;
    s_axis_cq_tdata      = data;
    s_axis_cq_tkeep      = 16'hFFFF;
    s_axis_cq_tuser      = '0;
    s_axis_cq_tuser[3:0] = be;
    s_axis_cq_tuser[96]  = disc;
    s_axis_cq_tlast      = last;
    while (!s_axis_cq_tready && n < 50) begin
      tick();
      n++;
    end
    check("cq_accept", s_axis_cq_tready, 1);
    tick();
    s_axis_cq_tvalid = 1'b0;
    s_axis_cq_tlast  = 1'b0;
  endtask

  task automatic send_req(input req_t r, input int extra);
    send_beat(cq_sop(r), r.be, r.disc, extra == 0);
    for (int i = 1; i <= extra; i++) send_beat({16{$urandom()}}, r.be, r.disc, i == extra);
  endtask

  // Entered in the reg_rd_en cycle; returns in the first cycle a completion is due.
  // lat = 0 means the register bus never answers.
  task automatic read_wait(input req_t r, input int lat, output logic [31:0] data);
    logic [63:0] byte_addr;
    byte_addr = {r.dw_addr, 2'b00};
    check("rd_en", reg_rd_en, 1);
    check("rd_addr", reg_addr, byte_addr[ADDR_W-1:0]);
    check("rd_be", reg_be, r.be);
    check("rd_cq_tready", s_axis_cq_tready, 0);
    data = TMO_DATA;
    for (int c = 1; c <= TMO; c++) begin
      tick();
      check("rd_wait", {m_axis_cc_tvalid, reg_rd_en, s_axis_cq_tready}, 0);
      if (c == lat) begin
        data         = $urandom();
        reg_rdata    = data;
        reg_rd_valid = 1'b1;
        tick();
        reg_rd_valid = 1'b0;
        reg_rdata    = $urandom();
        break;
      end
    end
    if (lat == 0) tick();
  endtask

  task automatic cpl_check(input req_t r, input bit ur, input logic [31:0] data, input int bp);
    logic [511:0] exp;
    exp = exp_cc(r, ur, data);
    m_axis_cc_tready = (bp == 0);
    check("cc_tvalid", m_axis_cc_tvalid, 1);
    check("cc_tdata", m_axis_cc_tdata, exp);
    check("cc_tkeep", m_axis_cc_tkeep, ur ? 16'h0007 : 16'h000F);
    check("cc_tlast_tuser", {m_axis_cc_tlast, m_axis_cc_tuser}, {1'b1, 81'd0});
    check("cc_cq_tready", s_axis_cq_tready, 0);
    for (int i = 0; i < bp; i++) begin
      tick();
      check("cc_hold", {m_axis_cc_tvalid, s_axis_cq_tready}, 2'b10);
      check("cc_hold_data", m_axis_cc_tdata, exp);
      if (i == bp - 1) m_axis_cc_tready = 1'b1;
    end
    tick();
    check("cc_done", {m_axis_cc_tvalid, s_axis_cq_tready}, 2'b01);
  endtask

  task automatic run_txn(input req_t r, input int extra, input int lat, input int bp);
    logic [63:0] byte_addr;
    logic [31:0] data;
    act_e act;
    act = classify(r);
    byte_addr = {r.dw_addr, 2'b00};
    send_req(r, extra);
    case (act)
      ACT_WR: begin
        check("wr_en", reg_wr_en, 1);
        check("wr_addr", reg_addr, byte_addr[ADDR_W-1:0]);
        check("wr_data", reg_wdata, r.wdata);
        check("wr_be", reg_be, r.be);
        check("wr_no_side", {reg_rd_en, m_axis_cc_tvalid}, 0);
        tick();
        check("wr_one_cycle", {reg_wr_en, m_axis_cc_tvalid}, 0);
        check("wr_next_accept", s_axis_cq_tready, 1);
      end
      ACT_RD: begin
        read_wait(r, lat, data);
        cpl_check(r, 1'b0, data, bp);
      end
      ACT_UR: cpl_check(r, 1'b1, 32'h0, bp);
      default: repeat (3) begin
        check("drop_quiet", {reg_wr_en, reg_rd_en, m_axis_cc_tvalid, !s_axis_cq_tready}, 0);
        tick();
      end
    endcase
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, {s_axis_cq_tready, m_axis_cc_tvalid, m_axis_cc_tlast, m_axis_cc_tkeep,
                          m_axis_cc_tuser, reg_wr_en, reg_rd_en, reg_be}, '0);
    check({tag, "_bus"}, {reg_addr, reg_wdata}, '0);
    check({tag, "_tdata"}, m_axis_cc_tdata, '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    req_t r;
    int kind, extra, lat, bp, dw;
    logic [31:0] data;

    user_reset       = 1'b1;
    s_axis_cq_tvalid = 1'b0;
    s_axis_cq_tdata  = '0;
    s_axis_cq_tkeep  = '0;
    s_axis_cq_tuser  = '0;
    s_axis_cq_tlast  = 1'b0;
    m_axis_cc_tready = 1'b1;
    reg_rdata        = '0;
    reg_rd_valid     = 1'b0;
    repeat (3) tick();
    check_reset("reset");
    user_reset = 1'b0;

    // Single-DW write to 0x0_1234.
    r = rand_req();
    r.req_type = 4'b0001; r.dw_addr = 62'h48D; r.be = 4'hF; r.wdata = 32'hA5A5_0001;
    run_txn(r, 0, 0, 0);

    // Read of 0x40, data returned 3 cycles after the strobe.
    r = rand_req();
    r.dw_addr = 62'h10; r.tag = 8'h1C; r.req_id = 16'h0100; r.be = 4'hF;
    run_txn(r, 0, 3, 0);

    // be 1100 with ten cycles of CC backpressure.
    r = rand_req();
    r.be = 4'b1100;
    run_txn(r, 0, 2, 10);

    // No register answer: timeout data; then an answer landing exactly on the timeout cycle.
    r = rand_req();
    run_txn(r, 0, 0, 0);
    r = rand_req();
    run_txn(r, 0, TMO, 1);
    r = rand_req();
    run_txn(r, 0, 1, 0);

    // Two-DW read over two beats gets UR; discontinued write is dropped.
    r = rand_req();
    r.dw_cnt = 11'd2;
    run_txn(r, 1, 0, 0);
    r = rand_req();
    r.req_type = 4'b0001; r.disc = 1'b1;
    run_txn(r, 0, 0, 0);

    // Reset while waiting for read data.
    r = rand_req();
    send_req(r, 0);
    check("rst_rdwait_pre", reg_rd_en, 1);
    tick();
    tick();
    user_reset = 1'b1;
    tick();
    check_reset("rst_rdwait");
    user_reset = 1'b0;
    repeat (TMO + 4) begin
      tick();
      check("rst_rdwait_quiet", {m_axis_cc_tvalid, reg_rd_en, reg_wr_en}, 0);
    end

    // Reset while the completion is back-pressured.
    r = rand_req();
    m_axis_cc_tready = 1'b0;
    send_req(r, 0);
    read_wait(r, 2, data);
    check("rst_cpl_pre", m_axis_cc_tvalid, 1);
    tick();
    tick();
    user_reset = 1'b1;
    tick();
    check_reset("rst_cpl");
    user_reset = 1'b0;
    repeat (5) begin
      tick();
      check("rst_cpl_quiet", m_axis_cc_tvalid, 0);
    end
    m_axis_cc_tready = 1'b1;

    // Normal read after the resets.
    r = rand_req();
    r.be = 4'b0110;
    run_txn(r, 0, 4, 2);

    // Random mix.
    for (int n = 0; n < 60; n++) begin
      r     = rand_req();
      extra = 0;
      kind  = $urandom_range(0, 9);
      dw    = $urandom_range(0, 2047);
      if (dw == 1) dw = 2;
      case (kind)
        0, 1, 2, 3: r.req_type = 4'b0001;
        4, 5, 6:    r.req_type = 4'b0000;
        7: begin
          r.dw_cnt = 11'(dw);
          extra    = $urandom_range(0, 2);
        end
        8: begin
          r.req_type = 4'($urandom_range(2, 15));
          r.dw_cnt   = 11'($urandom_range(0, 3));
          extra      = $urandom_range(0, 1);
        end
        default: begin
          r.req_type = 4'($urandom_range(0, 1));
          r.disc     = 1'b1;
        end
      endcase
      lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TMO);
      bp  = $urandom_range(0, 3);
      run_txn(r, extra, lat, bp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
